// File: rtl/vote_tally_mux_pkg.sv
// Shared constants and types for the vote tally / 7-segment readout block.
// Segment codes are {a,b,c,d,e,f,g}, active-low; digit enables are active-low.
package vm_pkg;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [7:0] AN_OFF   = 8'hFF;
    localparam logic [7:0] AN_UNITS = 8'b1111_1110;
    localparam logic [7:0] AN_TENS  = 8'b1111_1101;
    localparam logic [7:0] AN_WIN   = 8'b0111_1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } win_state_t;

    typedef enum logic [1:0] {
        DIG_UNITS,
        DIG_TENS,
        DIG_WIN
    } digit_t;

endpackage

// File: rtl/vote_tally_mux_if.sv
// Button/switch inputs and 7-segment/result outputs of the vote tally block.
// The master side drives the board inputs; the slave side is the tally logic.
interface vote_tally_mux_if #(
    parameter int unsigned N_CAND = 4,
    parameter int unsigned SEL_W  = 2
);

    logic              clear;
    logic              lock;
    logic [N_CAND-1:0] vote;
    logic [SEL_W-1:0]  sel;
    logic              show_win;
    logic              scan_tick;
    logic [6:0]        seg;
    logic [7:0]        an;
    logic              vote_ack;
    logic              vote_rej;
    logic [SEL_W-1:0]  winner;
    logic              tie;
    logic              result_valid;

    modport master (
        output clear, lock, vote, sel, show_win, scan_tick,
        input  seg, an, vote_ack, vote_rej, winner, tie, result_valid
    );

    modport slave (
        input  clear, lock, vote, sel, show_win, scan_tick,
        output seg, an, vote_ack, vote_rej, winner, tie, result_valid
    );

endinterface

// File: rtl/vote_tally_mux_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module seg7_decode
    import vm_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/vote_tally_mux.sv
// N-candidate vote counter: synchronised press detection, saturating counts,
// sequential winner/tie scan and a multiplexed two-digit + winner readout.
module vote_tally_mux
    import vm_pkg::*;
#(
    parameter int unsigned N_CAND    = 4,
    parameter int unsigned MAX_VOTES = 99,
    parameter int unsigned CNT_W     = 7,
    parameter int unsigned SEL_W     = 2
) (
    input logic             clock,
    input logic             rst_n,
    vote_tally_mux_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CAND - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_VOTES);

    logic [N_CAND-1:0] sync1, sync2, prev;
    logic [N_CAND-1:0] rise;
    logic [CNT_W-1:0]  count [N_CAND];
    logic [3:0]        n_rise;
    logic [SEL_W-1:0]  rise_idx;
    logic              do_inc, do_rej, cnt_changed;
    logic              ack_q, rej_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= bus.vote;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    always_comb begin
        n_rise   = '0;
        rise_idx = '0;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            if (rise[i]) begin
                n_rise   = n_rise + 4'd1;
                rise_idx = SEL_W'(i);
            end
        end
    end

    // Clear and lock both swallow any edge seen this cycle without a pulse.
    always_comb begin
        do_inc = 1'b0;
        do_rej = 1'b0;
        if (!bus.clear && !bus.lock) begin
            if (n_rise == 4'd1) begin
                if (count[rise_idx] < CNT_MAX) do_inc = 1'b1;
                else                           do_rej = 1'b1;
            end else if (n_rise > 4'd1) begin
                do_rej = 1'b1;
            end
        end
    end

    assign cnt_changed = bus.clear | do_inc;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CAND; i++) count[i] <= '0;
            ack_q <= 1'b0;
            rej_q <= 1'b0;
        end else begin
            ack_q <= do_inc;
            rej_q <= do_rej;
            if (bus.clear) begin
                for (int unsigned i = 0; i < N_CAND; i++) count[i] <= '0;
            end else if (do_inc) begin
                count[rise_idx] <= count[rise_idx] + CNT_W'(1);
            end
        end
    end

    win_state_t       state;
    logic [SEL_W-1:0] scan_idx, best_idx, winner_q;
    logic [CNT_W-1:0] best_val, scan_val;
    logic             tie_acc, tie_q, valid_q;

    assign scan_val = count[scan_idx];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            scan_idx <= '0;
            best_idx <= '0;
            best_val <= '0;
            tie_acc  <= 1'b0;
            winner_q <= '0;
            tie_q    <= 1'b1;
            valid_q  <= 1'b1;
        end else if (cnt_changed) begin
            state    <= ST_SCAN;
            scan_idx <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    // Index 0 seeds the running max; only a strictly larger value moves argmax.
                    if (scan_idx == '0) begin
                        best_val <= scan_val;
                        best_idx <= '0;
                        tie_acc  <= 1'b0;
                    end else if (scan_val > best_val) begin
                        best_val <= scan_val;
                        best_idx <= scan_idx;
                        tie_acc  <= 1'b0;
                    end else if (scan_val == best_val) begin
                        tie_acc  <= 1'b1;
                    end
                    if (scan_idx == LAST_IDX) state <= ST_DONE;
                    else                      scan_idx <= scan_idx + SEL_W'(1);
                end
                ST_DONE: begin
                    winner_q <= best_idx;
                    tie_q    <= tie_acc;
                    valid_q  <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [CNT_W-1:0] sel_cnt;
    logic             sel_bad;
    logic [3:0]       units_q, tens_q;
    logic             cnt_blank_q;

    always_comb begin
        sel_cnt = '0;
        sel_bad = 1'b1;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            if (SEL_W'(i) == bus.sel) begin
                sel_cnt = count[i];
                sel_bad = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            units_q     <= '0;
            tens_q      <= '0;
            cnt_blank_q <= 1'b1;
        end else begin
            units_q     <= 4'(sel_cnt % CNT_W'(10));
            tens_q      <= 4'(sel_cnt / CNT_W'(10));
            cnt_blank_q <= sel_bad;
        end
    end

    digit_t     ptr, cur, next_ptr;
    logic [3:0] mux_digit;
    logic       mux_blank;
    logic [7:0] mux_an;
    logic [6:0] dec_seg;
    logic [6:0] seg_q;
    logic [7:0] an_q;

    // A pointer parked on the winner digit after show_win drops falls back to units.
    assign cur = (ptr == DIG_WIN && !bus.show_win) ? DIG_UNITS : ptr;

    always_comb begin
        mux_digit = '0;
        mux_blank = 1'b1;
        mux_an    = AN_OFF;
        next_ptr  = DIG_UNITS;
        case (cur)
            DIG_UNITS: begin
                mux_digit = units_q;
                mux_blank = cnt_blank_q;
                mux_an    = AN_UNITS;
                next_ptr  = DIG_TENS;
            end
            DIG_TENS: begin
                mux_digit = tens_q;
                mux_blank = cnt_blank_q || (tens_q == 4'd0);
                mux_an    = AN_TENS;
                next_ptr  = bus.show_win ? DIG_WIN : DIG_UNITS;
            end
            DIG_WIN: begin
                mux_digit = tie_q ? 4'd0 : 4'(winner_q) + 4'd1;
                mux_blank = !valid_q;
                mux_an    = AN_WIN;
                next_ptr  = DIG_UNITS;
            end
            default: begin
                mux_digit = '0;
                mux_blank = 1'b1;
                mux_an    = AN_OFF;
                next_ptr  = DIG_UNITS;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .digit (mux_digit),
        .blank (mux_blank),
        .seg   (dec_seg)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= DIG_UNITS;
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else if (bus.scan_tick) begin
            ptr   <= next_ptr;
            seg_q <= dec_seg;
            an_q  <= mux_an;
        end
    end

    assign bus.seg          = seg_q;
    assign bus.an           = an_q;
    assign bus.vote_ack     = ack_q;
    assign bus.vote_rej     = rej_q;
    assign bus.winner       = winner_q;
    assign bus.tie          = tie_q;
    assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_vote_tally_mux.sv
// Randomised self-checking bench for vote_tally_mux against a count-level model.
module tb_vote_tally_mux;

    localparam int unsigned N_CAND    = 4;
    localparam int unsigned MAX_VOTES = 99;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned SEL_W     = 2;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    vote_tally_mux_if #(.N_CAND(N_CAND), .SEL_W(SEL_W)) bus ();

    vote_tally_mux #(
        .N_CAND    (N_CAND),
        .MAX_VOTES (MAX_VOTES),
        .CNT_W     (CNT_W),
        .SEL_W     (SEL_W)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0, n_ack = 0, n_rej = 0, n_vrise = 0, t_ack = 0, t_valid = 0;
    logic        valid_d = 1'b0;
    int unsigned m_cnt [N_CAND];
    int unsigned m_ptr = 0;
    logic [6:0]  seg_tab [10];

    always @(posedge clock) begin
        cyc++;
        #1;
        if (bus.vote_ack === 1'b1) begin
            n_ack++;
            t_ack = cyc;
        end
        if (bus.vote_rej === 1'b1) n_rej++;
        if (bus.result_valid === 1'b1 && valid_d !== 1'b1) begin
            n_vrise++;
            t_valid = cyc;
        end
        valid_d = bus.result_valid;
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    function automatic void model_win(output int unsigned w, output bit t);
        int unsigned mx, nmx;
        mx  = 0;
        nmx = 0;
        w   = 0;
        foreach (m_cnt[i]) if (m_cnt[i] > mx) mx = m_cnt[i];
        foreach (m_cnt[i]) begin
            if (m_cnt[i] == mx) begin
                if (nmx == 0) w = i;
                nmx++;
            end
        end
        t = (nmx > 1);
    endfunction

    task automatic press(input logic [N_CAND-1:0] mask, input int unsigned hold,
                         input bit lk, output bit acked);
        int unsigned ones, idx, a0, r0, exp_ack, exp_rej;
        ones = 0;
        idx  = 0;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            if (mask[i]) begin
                ones++;
                idx = i;
            end
        end
        exp_ack = 0;
        exp_rej = 0;
        if (!lk && ones == 1) begin
            if (m_cnt[idx] < MAX_VOTES) begin
                exp_ack = 1;
                m_cnt[idx]++;
            end else begin
                exp_rej = 1;
            end
        end else if (!lk && ones > 1) begin
            exp_rej = 1;
        end
        a0 = n_ack;
        r0 = n_rej;
        bus.lock = lk;
        bus.vote = mask;
        repeat (hold) step();
        bus.vote = '0;
        repeat (5) step();
        bus.lock = 1'b0;
        check_eq("ack_count", n_ack - a0, exp_ack);
        check_eq("rej_count", n_rej - r0, exp_rej);
        acked = (exp_ack == 1);
    endtask

    task automatic do_clear();
        int unsigned a0, r0;
        a0 = n_ack;
        r0 = n_rej;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        step();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        check_eq("clear_ack", n_ack - a0, 0);
        check_eq("clear_rej", n_rej - r0, 0);
    endtask

    task automatic settle(input bit chk_lat);
        int unsigned k, w;
        bit          t;
        k = 0;
        while (bus.result_valid !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        if (k >= 40) begin
            check_eq("valid_timeout", 0, 1);
        end else begin
            model_win(w, t);
            check_eq("winner", 32'(bus.winner), w);
            check_eq("tie", 32'(bus.tie), 32'(t));
            if (chk_lat) check_eq("valid_latency", t_valid - t_ack, N_CAND + 1);
        end
    endtask

    task automatic tick_check(input int unsigned s, input bit sw);
        int unsigned shown, c, w, nxt;
        bit          t;
        logic [6:0]  es;
        logic [7:0]  ean;
        bus.sel      = SEL_W'(s);
        bus.show_win = sw;
        step();
        bus.scan_tick = 1'b1;
        step();
        bus.scan_tick = 1'b0;
        shown = (m_ptr == 7 && !sw) ? 0 : m_ptr;
        c = m_cnt[s];
        model_win(w, t);
        if (shown == 0) begin
            es  = seg_tab[c % 10];
            nxt = 1;
        end else if (shown == 1) begin
            es  = (c / 10 == 0) ? 7'h7F : seg_tab[c / 10];
            nxt = sw ? 7 : 0;
        end else begin
            es  = t ? seg_tab[0] : seg_tab[w + 1];
            nxt = 0;
        end
        ean = 8'hFF;
        ean[shown] = 1'b0;
        m_ptr = nxt;
        check_eq("seg", 32'(bus.seg), 32'(es));
        check_eq("an", 32'(bus.an), 32'(ean));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        check_eq({tag, "_an"}, 32'(bus.an), 32'hFF);
        check_eq({tag, "_ack"}, 32'(bus.vote_ack), 0);
        check_eq({tag, "_rej"}, 32'(bus.vote_rej), 0);
        check_eq({tag, "_winner"}, 32'(bus.winner), 0);
        check_eq({tag, "_tie"}, 32'(bus.tie), 1);
        check_eq({tag, "_valid"}, 32'(bus.result_valid), 1);
    endtask

    initial begin
        logic [N_CAND-1:0] mask;
        bit                acked;
        int unsigned       a0, rv0, tA, k, r, i, j;

        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        foreach (m_cnt[n]) m_cnt[n] = 0;
        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.lock      = 1'b0;
        bus.vote      = '0;
        bus.sel       = '0;
        bus.show_win  = 1'b0;
        bus.scan_tick = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // One held press counts once
        press(4'b0100, 20, 1'b0, acked);
        settle(acked);
        tick_check(2, 1'b0);
        tick_check(2, 1'b0);

        // Simultaneous presses rejected, then clear
        press(4'b0011, 2, 1'b0, acked);
        settle(1'b0);
        do_clear();
        settle(1'b0);

        // Saturation at MAX_VOTES
        for (int n = 0; n < 100; n++) begin
            press(4'b1000, 1, 1'b0, acked);
            settle(acked);
        end
        tick_check(3, 1'b0);
        tick_check(3, 1'b0);

        // Shared maximum, then break the tie
        do_clear();
        settle(1'b0);
        repeat (5) press(4'b0001, 1, 1'b0, acked);
        repeat (5) press(4'b0010, 1, 1'b0, acked);
        repeat (2) press(4'b0100, 1, 1'b0, acked);
        settle(acked);
        repeat (3) tick_check(0, 1'b1);
        press(4'b0010, 1, 1'b0, acked);
        settle(acked);
        repeat (3) tick_check(1, 1'b1);
        tick_check(1, 1'b1);
        tick_check(1, 1'b0);

        // Locked press is ignored
        press(4'b0001, 3, 1'b1, acked);
        settle(1'b0);

        // Reset in the middle of a scan
        a0 = n_ack;
        bus.vote = 4'b0100;
        k = 0;
        while (n_ack == a0 && k < 10) begin
            step();
            k++;
        end
        check_eq("midscan_ack", n_ack - a0, 1);
        bus.vote = '0;
        step();
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        step();
        rst_n = 1'b1;
        foreach (m_cnt[n]) m_cnt[n] = 0;
        m_ptr = 0;
        repeat (3) step();
        settle(1'b0);
        tick_check(2, 1'b0);

        // Vote landing mid-scan restarts the scan
        a0 = n_ack;
        bus.vote = 4'b0001;
        k = 0;
        while (n_ack == a0 && k < 10) begin
            step();
            k++;
        end
        tA  = t_ack;
        rv0 = n_vrise;
        m_cnt[0]++;
        bus.vote = 4'b0010;
        k = 0;
        while (n_ack == a0 + 1 && k < 10) begin
            step();
            k++;
        end
        check_eq("restart_gap", t_ack - tA, 3);
        m_cnt[1]++;
        bus.vote = '0;
        settle(1'b1);
        check_eq("valid_rises", n_vrise - rv0, 1);
        tick_check(1, 1'b0);

        // Randomised traffic
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            i = $urandom_range(0, N_CAND - 1);
            mask = '0;
            mask[i] = 1'b1;
            acked = 1'b0;
            if (r == 9) begin
                do_clear();
            end else begin
                if (r >= 6 && r < 8) begin
                    j = (i + 1 + $urandom_range(0, N_CAND - 2)) % N_CAND;
                    mask[j] = 1'b1;
                end
                press(mask, $urandom_range(1, 4), r == 8, acked);
            end
            settle(acked);
            tick_check($urandom_range(0, N_CAND - 1), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vote_tally_mux.md
Name: vote_tally_mux

Overview:
- Parametrised N-candidate vote counter with multiplexed 7-segment readout; successor to the single-digit 4-candidate voting machine.
- Adds:
  - input synchronisation and press edge detection (one vote per press)
  - rejection of ambiguous ballots
  - saturating counts
  - a sequential winner/tie scan
  - two-digit decimal display of the selected candidate, time-multiplexed with the winner digit.
- Sits between the board buttons/switches and the 7-segment pins.
- scan_tick comes from the existing clock-divider block.

Parameters:
- N_CAND, 4, number of candidates (2..9).
- MAX_VOTES, 99, saturation limit per candidate (≤99).
- CNT_W, 7, counter width; must hold MAX_VOTES.
- SEL_W, 2, index width, equal to $clog2(N_CAND).

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all counts; priority over votes.
- lock  in  1  polls closed; votes ignored while high.
- vote  in  N_CAND  raw candidate buttons, asynchronous level inputs.
- sel  in  SEL_W  candidate whose count is displayed.
- show_win  in  1  include the winner digit in the display scan.
- scan_tick  in  1  one-cycle pulse that advances the digit multiplexer.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- an  out  8  digit enables, active-low, at most one low.
- vote_ack  out  1  one-cycle pulse: vote counted.
- vote_rej  out  1  one-cycle pulse: ballot rejected.
- winner  out  SEL_W  index of the leading candidate.
- tie  out  1  maximum is shared, including the all-zero case.
- result_valid  out  1  winner/tie are current.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - all counts 0; sync/edge flops 0
  - seg=7'b1111111, an=8'hFF
  - vote_ack=0, vote_rej=0
  - winner=0, tie=1, result_valid=1
  - scan pointer at digit 0
- Input path: vote passes through a 2-flop synchroniser, then a registered edge detector. Bit sampled high at edge k → count updates at edge k+2; vote_ack/vote_rej high for the cycle following edge k+2.
- Per cycle, evaluated in priority order:
  1. clear=1: all counts ← 0; no ack, no rej.
  2. lock=1: pending edges are discarded silently.
  3. Exactly one rising edge on candidate i:
     - count[i] < MAX_VOTES: count[i] += 1, vote_ack.
     - count[i] == MAX_VOTES: count unchanged (no wrap), vote_rej.
  4. Two or more rising edges in the same cycle: no count changes, vote_rej.
- A held button counts once; a release followed by a new press counts again.
- Winner FSM, states IDLE, SCAN, DONE:
  - Any count change or clear forces SCAN with index 0 and drops result_valid.
  - SCAN visits one candidate per cycle, tracking max value, argmax (lowest index wins ties) and a tie flag. Tie is set on equal-to-max and cleared when a strictly greater value is found.
  - After N_CAND cycles → DONE: winner/tie registered, result_valid=1 on the next cycle, then IDLE.
  - Latency from the count update to result_valid is N_CAND+1 cycles.
  - A count change during SCAN restarts the scan from 0.
  - winner/tie hold their previous values while result_valid=0.
  - All counts equal (including all zero) → tie=1, winner=0.
- Display:
  - Active digit set: an[0] = units of count[sel], an[1] = tens of count[sel]; an[7] = winner digit, added when show_win=1.
  - The pointer advances cyclically over the active set on each scan_tick. seg/an are registered and update in the cycle after scan_tick.
  - If show_win falls while the pointer is on digit 7, the pointer goes to digit 0 on the next tick.
  - Tens digit is blanked (SEG_OFF) when zero.
  - sel ≥ N_CAND → both count digits blank.
  - Winner digit shows winner+1, shows 0 when tie=1, and shows SEG_OFF while result_valid=0.
  - Decimal split is combinational (divide/modulo 10 on CNT_W bits) followed by a register.
- Segment codes, 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. SEG_OFF = 1111111.
- Reset asserted mid-scan or mid-vote aborts immediately to the reset values; no partial increment survives.

Decomposition:
- Package vm_pkg holds:
  - the SEG_0..SEG_9 and SEG_OFF constants
  - AN_OFF=8'hFF and digit-enable constants (AN_UNITS, AN_TENS, AN_WIN)
  - the winner FSM state enum
- One sub-module, seg7_decode: 4-bit digit in, blank flag in, 7-bit seg out; purely combinational.
- Instantiate seg7_decode once, on the selected multiplexer digit.

Test Plan:
- Reset, then press vote[2] once and hold for 20 cycles → count[2]=1, exactly one vote_ack, no vote_rej; result_valid returns N_CAND+1 cycles after the update with winner=2, tie=0.
- vote[0] and vote[1] rise in the same cycle → vote_rej pulse, counts unchanged. Then clear=1 → all counts 0, tie=1, winner=0.
- 100 separate presses of vote[3] → count[3]=99; the 100th press gives vote_rej. sel=3 with scan_tick pulses → an cycles 11111110 (seg 0000100), 11111101 (seg 0000100).
- Counts {5,5,2,0}, show_win=1 → scan visits an[0], an[1], an[7]; the winner digit shows SEG_0 (tie). One more vote[1] → the winner digit shows SEG_2 after the rescan.
- lock=1 during a press of vote[0] → no count change, no ack/rej. Assert rst_n=0 mid-SCAN → outputs at reset values immediately, asynchronously.
- sel=1 with count[1]=7 → tens blank (1111111), units 0001111. Pulse vote[1] during SCAN → the scan restarts and result_valid stays low a further N_CAND+1 cycles.
